// File: rtl/wb_pl_ram.sv
// wb_pl_ram: pipelined Wishbone slave word memory with an in-order command FIFO and fixed wait states.
// Optional build macro WB_PL_RAM_ERR_EN: misaligned or out-of-range requests terminate with err.
//
// state  | meaning
// S_IDLE | no request in service
// S_WAIT | request in service, counting down wait states
// S_RESP | request in service terminates this cycle (ack/err, write commit)

module wb_pl_ram #(
  parameter int MEM_WORDS   = 1024,
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_mi,
  output logic [31:0] dat_so,
  output logic        ack,
  output logic        err,
  output logic        stall
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          push, pop, commit;

  logic          fifo_we_q  [FIFO_DEPTH];
  logic          fifo_bad_q [FIFO_DEPTH];
  logic [AW-1:0] fifo_idx_q [FIFO_DEPTH];
  logic [3:0]    fifo_sel_q [FIFO_DEPTH];
  logic [31:0]   fifo_dat_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          svc_we_q, svc_bad_q;
  logic [AW-1:0] svc_idx_q;
  logic [3:0]    svc_sel_q;
  logic [31:0]   svc_dat_q, svc_rdata_q;
  logic [31:0]   dat_so_q;

  logic [31:0]   mem_q [MEM_WORDS];

  logic          req_bad;
  logic [AW-1:0] req_idx;
  logic          h_we, h_bad;
  logic [AW-1:0] h_idx;
  logic [3:0]    h_sel;
  logic [31:0]   h_dat, head_rdata;
  logic          unused_adr;

`ifdef WB_PL_RAM_ERR_EN
  assign req_bad = (adr[1:0] != 2'b00) || ({1'b0, adr} >= (33'(MEM_WORDS) << 2));
`else
  assign req_bad = 1'b0;
`endif
  assign req_idx    = adr[AW+1:2];
  assign unused_adr = ^{adr[31:AW+2], adr[1:0]};

  assign stall = (count_q == CW'(FIFO_DEPTH));
  assign push  = cyc & stb & ~stall;

  assign h_we  = fifo_we_q[rd_ptr_q];
  assign h_bad = fifo_bad_q[rd_ptr_q];
  assign h_idx = fifo_idx_q[rd_ptr_q];
  assign h_sel = fifo_sel_q[rd_ptr_q];
  assign h_dat = fifo_dat_q[rd_ptr_q];

  assign commit = (state_q == S_RESP) & cyc & svc_we_q & ~svc_bad_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]  <= we;
      fifo_bad_q[wr_ptr_q] <= req_bad;
      fifo_idx_q[wr_ptr_q] <= req_idx;
      fifo_sel_q[wr_ptr_q] <= sel;
      fifo_dat_q[wr_ptr_q] <= dat_mi;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (svc_sel_q[i]) mem_q[svc_idx_q][8*i +: 8] <= svc_dat_q[8*i +: 8];
      end
    end
  end

  // A read popped on the edge that commits the preceding write sees that write's lanes.
  always_comb begin
    head_rdata = mem_q[h_idx];
    if (commit && (svc_idx_q == h_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (svc_sel_q[i]) head_rdata[8*i +: 8] = svc_dat_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: pop = (count_q != '0);
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_RESP: begin
        pop = (count_q != '0);
        if (count_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      if (WAIT_STATES == 0) begin
        state_d = S_RESP;
      end else begin
        state_d = S_WAIT;
        cnt_d   = WS_LOAD;
      end
    end
    // Dropping cyc abandons everything queued or in service.
    if (!cyc) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      pop     = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!cyc) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      svc_we_q    <= 1'b0;
      svc_bad_q   <= 1'b0;
      svc_idx_q   <= '0;
      svc_sel_q   <= 4'h0;
      svc_dat_q   <= 32'h0;
      svc_rdata_q <= 32'h0;
      dat_so_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop) begin
        svc_we_q    <= h_we;
        svc_bad_q   <= h_bad;
        svc_idx_q   <= h_idx;
        svc_sel_q   <= h_sel;
        svc_dat_q   <= h_dat;
        svc_rdata_q <= head_rdata;
      end
      if (pop && (state_d == S_RESP) && !h_we && !h_bad) begin
        dat_so_q <= head_rdata;
      end else if ((state_q == S_WAIT) && (state_d == S_RESP) && !svc_we_q && !svc_bad_q) begin
        dat_so_q <= svc_rdata_q;
      end
    end
  end

  assign dat_so = dat_so_q;
  assign ack    = (state_q == S_RESP) & ~svc_bad_q & cyc;
  assign err    = (state_q == S_RESP) &  svc_bad_q & cyc;

endmodule

// File: tb/tb_wb_pl_ram.sv
// tb_wb_pl_ram: drives two wb_pl_ram instances (0 and 3 wait states) from one directed stream and
// checks them against a schedule-based model every cycle, plus literal expectations per scenario.

module tb_wb_pl_ram;

  logic        clk, rst, cyc, stb, we;
  logic [31:0] adr, dat_mi;
  logic [3:0]  sel;
  logic [31:0] dat_so0, dat_so3;
  logic        ack0, err0, stall0, ack3, err3, stall3;

  int n_cmp = 0;
  int n_fail = 0;
  int ncyc = 0;
  int acc0, acc3;

  wb_pl_ram #(.MEM_WORDS(1024), .FIFO_DEPTH(4), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .dat_mi(dat_mi), .dat_so(dat_so0), .ack(ack0), .err(err0), .stall(stall0));

  wb_pl_ram #(.MEM_WORDS(1024), .FIFO_DEPTH(4), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .dat_mi(dat_mi), .dat_so(dat_so3), .ack(ack3), .err(err3), .stall(stall3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each accepted request gets an absolute termination cycle
  // term = max(accept+2+WS, previous_term+1+WS); it sits in the FIFO until term-1-WS.
  typedef struct {
    int          k;
    logic        we;
    logic        bad;
    logic [9:0]  idx;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          term;
    int          popc;
  } req_t;

  req_t        pend[$];
  logic [31:0] mmem [2][1024];
  bit          mval [2][1024];
  logic [31:0] last_dat [2];
  bit          known [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic bad_of(input logic [31:0] a);
`ifdef WB_PL_RAM_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 32'd4096);
`else
    return (a[0] === 1'bx);
`endif
  endfunction

  task automatic model_cycle(input int k);
    int ws, hi, cnt, last_term, t;
    logic es, ea, ee, hterm;
    logic a_ack, a_err, a_stall;
    logic [31:0] a_dat;
    req_t r;
    ws = (k == 1) ? 3 : 0;
    if (k == 0) begin a_ack = ack0; a_err = err0; a_stall = stall0; a_dat = dat_so0; end
    else        begin a_ack = ack3; a_err = err3; a_stall = stall3; a_dat = dat_so3; end
    hi = -1;
    cnt = 0;
    for (int i = 0; i < pend.size(); i++) begin
      if (pend[i].k == k) begin
        if (hi < 0) hi = i;
        if (pend[i].popc >= ncyc) cnt++;
      end
    end
    es = (cnt == 4);
    hterm = (hi >= 0) && (pend[hi].term == ncyc);
    ea = 1'b0;
    ee = 1'b0;
    if (hterm) begin
      r = pend[hi];
      if (!r.we && !r.bad) begin
        last_dat[k] = mmem[k][r.idx];
        known[k]    = mval[k][r.idx];
      end
      if (cyc) begin ea = !r.bad; ee = r.bad; end
    end
    chk($sformatf("stall%0d@%0d", k*3, ncyc), 32'(a_stall), 32'(es));
    chk($sformatf("ack%0d@%0d", k*3, ncyc), 32'(a_ack), 32'(ea));
    chk($sformatf("err%0d@%0d", k*3, ncyc), 32'(a_err), 32'(ee));
    if (known[k]) chk($sformatf("dat_so%0d@%0d", k*3, ncyc), a_dat, last_dat[k]);
    if (!cyc) begin
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].k == k) pend.delete(i);
    end else begin
      if (hterm) begin
        if (r.we && !r.bad) begin
          for (int b = 0; b < 4; b++) if (r.sel[b]) mmem[k][r.idx][8*b +: 8] = r.dat[8*b +: 8];
          if (r.sel == 4'hF) mval[k][r.idx] = 1'b1;
        end
        pend.delete(hi);
      end
      if (stb && !es) begin
        last_term = -1000;
        for (int i = 0; i < pend.size(); i++) if (pend[i].k == k) last_term = pend[i].term;
        t = ncyc + 2 + ws;
        if (last_term + 1 + ws > t) t = last_term + 1 + ws;
        r.k = k; r.we = we; r.bad = bad_of(adr); r.idx = adr[11:2];
        r.sel = sel; r.dat = dat_mi; r.term = t; r.popc = t - 1 - ws;
        pend.push_back(r);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      pend.delete();
      for (int k = 0; k < 2; k++) begin last_dat[k] = 32'h0; known[k] = 1'b1; end
    end else begin
      model_cycle(0);
      model_cycle(1);
    end
    ncyc++;
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); acc0 += 32'(ack0); acc3 += 32'(ack3); endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_mi = d;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin tick(); cyc = 1'b1; stb = 1'b0; mid(); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; sel = 4'h0; dat_mi = 32'h0;
    acc0 = 0; acc3 = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset ack0", 32'(ack0), 32'd0);
    chk("reset stall3", 32'(stall3), 32'd0);
    chk("reset dat_so0", dat_so0, 32'h0);
    chk("reset dat_so3", dat_so3, 32'h0);
    tick(); rst = 1'b1; cyc = 1'b1;
    quiet(3);

    // write then read the same word back to back
    tick(); issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF); mid();
    tick(); issue(1'b0, 32'h10, 4'hF, 32'h0); mid();
    for (int c = 2; c <= 10; c++) begin
      tick(); stb = 1'b0; mid();
      case (c)
        2: chk("wr ack0 c2", 32'(ack0), 32'd1);
        3: begin chk("rd ack0 c3", 32'(ack0), 32'd1); chk("rd data0 c3", dat_so0, 32'hDEADBEEF); end
        4: chk("ack0 idle c4", 32'(ack0), 32'd0);
        5: chk("wr ack3 c5", 32'(ack3), 32'd1);
        9: begin chk("rd ack3 c9", 32'(ack3), 32'd1); chk("rd data3 c9", dat_so3, 32'hDEADBEEF); end
        default: ;
      endcase
    end
    quiet(5);

    // byte lanes
    tick(); issue(1'b1, 32'h20, 4'hF, 32'h11223344); mid();
    tick(); issue(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD); mid();
    tick(); issue(1'b0, 32'h20, 4'hF, 32'h0); mid();
    tick(); issue(1'b0, 32'h10, 4'hF, 32'h0); mid();
    for (int c = 4; c <= 18; c++) begin
      tick(); stb = 1'b0; mid();
      if (c == 4)  chk("lanes data0", dat_so0, 32'h11BB33DD);
      if (c == 5)  chk("other word0", dat_so0, 32'hDEADBEEF);
      if (c == 13) chk("lanes data3", dat_so3, 32'h11BB33DD);
      if (c == 17) chk("other word3", dat_so3, 32'hDEADBEEF);
    end
    quiet(5);

    // back-pressure: stb held for 8 cycles
    acc0 = 0; acc3 = 0;
    for (int c = 0; c < 8; c++) begin
      tick(); issue(1'b0, (c % 2 == 1) ? 32'h20 : 32'h10, 4'hF, 32'h0); mid();
      if (c == 4) chk("stall3 c4", 32'(stall3), 32'd0);
      if (c == 5) begin chk("stall3 c5", 32'(stall3), 32'd1); chk("ack3 c5", 32'(ack3), 32'd1); end
      if (c == 6) chk("stall3 c6", 32'(stall3), 32'd0);
      if (c == 7) chk("stall3 c7", 32'(stall3), 32'd1);
    end
    for (int c = 8; c < 32; c++) begin
      tick(); stb = 1'b0; mid();
      if (c == 9)  chk("ack3 c9", 32'(ack3), 32'd1);
      if (c == 10) chk("ack3 c10", 32'(ack3), 32'd0);
    end
    chk("bp acks0", 32'(acc0), 32'd8);
    chk("bp acks3", 32'(acc3), 32'd6);
    quiet(3);

    // abort with a write in its RESP cycle
    acc0 = 0; acc3 = 0;
    tick(); issue(1'b1, 32'h10, 4'hF, 32'h0BAD0BAD); mid();
    tick(); issue(1'b0, 32'h20, 4'hF, 32'h0); mid();
    tick(); issue(1'b0, 32'h20, 4'hF, 32'h0); cyc = 1'b0; mid();
    quiet(18);
    chk("abortA acks0", 32'(acc0), 32'd0);
    chk("abortA acks3", 32'(acc3), 32'd0);
    tick(); issue(1'b0, 32'h10, 4'hF, 32'h0); mid();
    for (int c = 1; c <= 6; c++) begin
      tick(); stb = 1'b0; mid();
      if (c == 2) begin chk("post-abort ack0", 32'(ack0), 32'd1); chk("post-abort data0", dat_so0, 32'hDEADBEEF); end
      if (c == 5) begin chk("post-abort ack3", 32'(ack3), 32'd1); chk("post-abort data3", dat_so3, 32'hDEADBEEF); end
    end
    quiet(3);
    acc0 = 0; acc3 = 0;
    tick(); issue(1'b0, 32'h10, 4'hF, 32'h0); mid();
    tick(); issue(1'b0, 32'h20, 4'hF, 32'h0); mid();
    tick(); issue(1'b0, 32'h10, 4'hF, 32'h0); mid();
    tick(); stb = 1'b0; cyc = 1'b0; mid();
    quiet(15);
    chk("abortC acks0", 32'(acc0), 32'd1);
    chk("abortC acks3", 32'(acc3), 32'd0);

    // misaligned and out-of-range reads
    tick(); issue(1'b1, 32'h0, 4'hF, 32'hCAFEF00D); mid();
    tick(); issue(1'b0, 32'h10, 4'hF, 32'h0); mid();
    tick(); issue(1'b0, 32'h2, 4'hF, 32'h0); mid();
    tick(); issue(1'b0, 32'h1000, 4'hF, 32'h0); mid();
    for (int c = 4; c <= 18; c++) begin
      tick(); stb = 1'b0; mid();
`ifdef WB_PL_RAM_ERR_EN
      if (c == 4)  begin chk("misal err0", 32'(err0), 32'd1); chk("misal ack0", 32'(ack0), 32'd0); chk("misal data0", dat_so0, 32'hDEADBEEF); end
      if (c == 5)  begin chk("range err0", 32'(err0), 32'd1); chk("range ack0", 32'(ack0), 32'd0); end
      if (c == 13) chk("misal err3", 32'(err3), 32'd1);
      if (c == 17) chk("range err3", 32'(err3), 32'd1);
`else
      if (c == 4)  begin chk("misal ack0", 32'(ack0), 32'd1); chk("misal data0", dat_so0, 32'hCAFEF00D); end
      if (c == 5)  begin chk("range ack0", 32'(ack0), 32'd1); chk("range data0", dat_so0, 32'hCAFEF00D); end
      if (c == 13) chk("misal data3", dat_so3, 32'hCAFEF00D);
      if (c == 17) chk("range ack3", 32'(ack3), 32'd1);
`endif
    end
    quiet(3);

    // asynchronous reset mid-stream
    tick(); issue(1'b0, 32'h10, 4'hF, 32'h0); mid();
    tick(); issue(1'b0, 32'h20, 4'hF, 32'h0); mid();
    tick(); issue(1'b0, 32'h10, 4'hF, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("rst ack0", 32'(ack0), 32'd0);
    chk("rst err0", 32'(err0), 32'd0);
    chk("rst stall0", 32'(stall0), 32'd0);
    chk("rst dat_so0", dat_so0, 32'h0);
    chk("rst ack3", 32'(ack3), 32'd0);
    chk("rst dat_so3", dat_so3, 32'h0);
    mid();
    tick(); stb = 1'b0; #1 rst = 1'b1; mid();
    acc0 = 0; acc3 = 0;
    quiet(20);
    chk("post-rst acks0", 32'(acc0), 32'd0);
    chk("post-rst acks3", 32'(acc3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
